// File: rtl/rect_fill_drawer.sv
// Rectangle fill engine feeding a 160x120 vga_adapter.
// On an accepted start it latches the rectangle, clips it to the screen and
// emits one plot per clock in raster order, then raises a one-cycle done.
module rect_fill_drawer #(
    parameter int X_RES = 160,
    parameter int Y_RES = 120,
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] width,
    input  logic [YW-1:0] height,
    input  logic [CW-1:0] colour_in,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [XW-1:0] X_MAX = XW'(X_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(Y_RES - 1);
    localparam logic [XW:0]   X_LIM = (XW+1)'(X_RES);
    localparam logic [YW:0]   Y_LIM = (YW+1)'(Y_RES);

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] xs_q, xs_d;     // left column, reload value for each row
    logic [XW-1:0] xe_q, xe_d;     // clipped right column
    logic [YW-1:0] ye_q, ye_d;     // clipped bottom row
    logic [CW-1:0] colour_q, colour_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [XW:0]   x_sum_s;
    logic [YW:0]   y_sum_s;
    logic [XW-1:0] xe_s;
    logic [YW-1:0] ye_s;
    logic          empty_s;

    // Clipped end coordinates and empty/off-screen detection from the live inputs
    always_comb begin
        // one extra bit so x0+width-1 cannot wrap before clipping
        x_sum_s = {1'b0, x0} + {1'b0, width} - {{XW{1'b0}}, 1'b1};
        y_sum_s = {1'b0, y0} + {1'b0, height} - {{YW{1'b0}}, 1'b1};
        if (x_sum_s > {1'b0, X_MAX}) begin
            xe_s = X_MAX;
        end else begin
            xe_s = x_sum_s[XW-1:0];
        end
        if (y_sum_s > {1'b0, Y_MAX}) begin
            ye_s = Y_MAX;
        end else begin
            ye_s = y_sum_s[YW-1:0];
        end
        empty_s = (width == {XW{1'b0}}) || (height == {YW{1'b0}}) ||
                  ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
    end

    // Next-state logic: raster walk over the latched rectangle
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        xs_d     = xs_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (empty_s) begin
                        // nothing to draw; FIN adds the cycle before done
                        state_d = S_FIN;
                    end else begin
                        // first pixel is presented right away so it lands the
                        // cycle after start is sampled
                        state_d  = S_DRAW;
                        xs_d     = x0;
                        xe_d     = xe_s;
                        ye_d     = ye_s;
                        x_d      = x0;
                        y_d      = y0;
                        colour_d = colour_in;
                        plot_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW: begin
                if (x_q == xe_q) begin
                    if (y_q == ye_q) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        x_d    = xs_q;
                        y_d    = y_q + {{(YW-1){1'b0}}, 1'b1};
                        plot_d = 1'b1;
                    end
                end else begin
                    x_d    = x_q + {{(XW-1){1'b0}}, 1'b1};
                    plot_d = 1'b1;
                end
            end
            S_FIN: begin
                if (done_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any draw without a done
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            x_q      <= {XW{1'b0}};
            y_q      <= {YW{1'b0}};
            xs_q     <= {XW{1'b0}};
            xe_q     <= {XW{1'b0}};
            ye_q     <= {YW{1'b0}};
            colour_q <= {CW{1'b0}};
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xs_q     <= xs_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
